// File: rtl/mw_pkg.sv
// ============================================================================
// mw_pkg : shared state encodings and BCD limits for the microwave cook timer
// Revision: 1.0
// ============================================================================
`default_nettype none

package mw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } mw_state_e;

  localparam logic [3:0] BCD_MAX_DIGIT     = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS      = 4'd5;
  localparam int         TICKS_PER_SEC_DEF = 100;

  function automatic logic is_bcd_digit(input logic [3:0] d);
    return d <= BCD_MAX_DIGIT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mw_bcd_time.sv
// ============================================================================
// mw_bcd_time : four-digit mm:ss BCD register with clear, shift-in, decrement
// Revision: 1.0
// ============================================================================
`default_nettype none

module mw_bcd_time
  import mw_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       shift_en,
  input  logic [3:0] shift_digit,
  input  logic       dec_en,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       is_zero,
  output logic       will_be_zero
);

  logic [3:0] mt_q, mt_d;
  logic [3:0] mo_q, mo_d;
  logic [3:0] st_q, st_d;
  logic [3:0] so_q, so_d;

  always_comb begin
    mt_d = mt_q;
    mo_d = mo_q;
    st_d = st_q;
    so_d = so_q;
    if (clr) begin
      mt_d = '0;
      mo_d = '0;
      st_d = '0;
      so_d = '0;
    end else if (dec_en) begin
      // Borrow ripples leftwards; seconds refill to 59 even if entered as e.g. 75.
      if (so_q != 4'd0) begin
        so_d = so_q - 4'd1;
      end else if (st_q != 4'd0) begin
        st_d = st_q - 4'd1;
        so_d = BCD_MAX_DIGIT;
      end else if (mo_q != 4'd0) begin
        mo_d = mo_q - 4'd1;
        st_d = BCD_MAX_TENS;
        so_d = BCD_MAX_DIGIT;
      end else begin
        mt_d = mt_q - 4'd1;
        mo_d = BCD_MAX_DIGIT;
        st_d = BCD_MAX_TENS;
        so_d = BCD_MAX_DIGIT;
      end
    end else if (shift_en) begin
      mt_d = mo_q;
      mo_d = st_q;
      st_d = so_q;
      so_d = shift_digit;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mt_q <= '0;
      mo_q <= '0;
      st_q <= '0;
      so_q <= '0;
    end else begin
      mt_q <= mt_d;
      mo_q <= mo_d;
      st_q <= st_d;
      so_q <= so_d;
    end
  end

  assign min_tens     = mt_q;
  assign min_ones     = mo_q;
  assign sec_tens     = st_q;
  assign sec_ones     = so_q;
  assign is_zero      = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);
  assign will_be_zero = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd1);

endmodule

`default_nettype wire

// File: rtl/mw_cook_timer.sv
// ============================================================================
// mw_cook_timer : keypad-loaded mm:ss countdown with cook/pause/done FSM.
// Optional MW_DONE_BEEP_EN adds a `beep` output for BEEP_SECS after DONE.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mw_cook_timer
  import mw_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
  parameter int TICK_W        = 16
`ifdef MW_DONE_BEEP_EN
  ,
  parameter int BEEP_SECS     = 3
`endif
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  output logic       mag,
  output logic       timer_done,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
`ifdef MW_DONE_BEEP_EN
  output logic       beep,
`endif
  output logic [2:0] state
);

  mw_state_e   state_q, state_d;
  logic [TICK_W-1:0] presc_q, presc_d;
  logic        mag_q, mag_d;
  logic        done_q, done_d;
  logic        startn_q, stopn_q, clearn_q;

  logic        time_clr, time_shift, time_dec;
  logic        is_zero, will_be_zero;

  logic        start_press, stop_press, clear_press;
  logic        digit_ok, shift_nonzero, tick;

`ifdef MW_DONE_BEEP_EN
  localparam int BEEP_CYC = BEEP_SECS * TICKS_PER_SEC;
  localparam int BEEP_W   = $clog2(BEEP_CYC + 1);
  logic              beep_q, beep_d;
  logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
`endif

  assign start_press   = startn_q & ~startn;
  assign stop_press    = stopn_q  & ~stopn;
  assign clear_press   = clearn_q & ~clearn;
  assign digit_ok      = digit_valid && is_bcd_digit(digit);
  assign shift_nonzero = |{min_ones, sec_tens, sec_ones, digit};
  assign tick          = (presc_q == TICK_W'(TICKS_PER_SEC - 1));

  mw_bcd_time u_time (
    .clk         (clk),
    .rstn        (rstn),
    .clr         (time_clr),
    .shift_en    (time_shift),
    .shift_digit (digit),
    .dec_en      (time_dec),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .is_zero     (is_zero),
    .will_be_zero(will_be_zero)
  );

  // Priority: clear > stop > door open > start > tick > digit.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    done_d     = 1'b0;
    time_clr   = 1'b0;
    time_shift = 1'b0;
    time_dec   = 1'b0;
    if (clear_press) begin
      state_d  = ST_IDLE;
      time_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_SET: begin
          if (state_q == ST_SET && start_press && door_closed && !is_zero) begin
            state_d = ST_COOK;
            presc_d = '0;
          end else if (digit_ok) begin
            time_shift = 1'b1;
            state_d    = shift_nonzero ? ST_SET : ST_IDLE;
          end
        end
        ST_COOK: begin
          if (stop_press || !door_closed) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            presc_d  = '0;
            time_dec = 1'b1;
            if (will_be_zero) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + TICK_W'(1);
          end
        end
        ST_PAUSE: begin
          if (stop_press) begin
            state_d  = ST_IDLE;
            time_clr = 1'b1;
          end else if (start_press && door_closed) begin
            state_d = ST_COOK;
            presc_d = '0;
          end
        end
        ST_DONE: begin
          if (stop_press || !door_closed) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          time_clr = 1'b1;
        end
      endcase
    end
    mag_d = (state_d == ST_COOK);
  end

`ifdef MW_DONE_BEEP_EN
  // Beep runs from DONE entry for BEEP_CYC cycles; leaving DONE cuts it short.
  always_comb begin
    beep_d     = 1'b0;
    beep_cnt_d = beep_cnt_q;
    if (state_d == ST_DONE) begin
      if (state_q != ST_DONE) begin
        beep_d     = 1'b1;
        beep_cnt_d = BEEP_W'(BEEP_CYC - 1);
      end else if (beep_cnt_q != '0) begin
        beep_d     = beep_q;
        beep_cnt_d = beep_cnt_q - BEEP_W'(1);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      mag_q      <= 1'b0;
      done_q     <= 1'b0;
      startn_q   <= 1'b1;
      stopn_q    <= 1'b1;
      clearn_q   <= 1'b1;
`ifdef MW_DONE_BEEP_EN
      beep_q     <= 1'b0;
      beep_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      mag_q      <= mag_d;
      done_q     <= done_d;
      startn_q   <= startn;
      stopn_q    <= stopn;
      clearn_q   <= clearn;
`ifdef MW_DONE_BEEP_EN
      beep_q     <= beep_d;
      beep_cnt_q <= beep_cnt_d;
`endif
    end
  end

  assign mag        = mag_q;
  assign timer_done = done_q;
  assign state      = state_q;
`ifdef MW_DONE_BEEP_EN
  assign beep       = beep_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mw_cook_timer.sv
// ============================================================================
// tb_mw_cook_timer : vector table, directed corner sequences and a random run
// compared cycle by cycle against an arithmetic mm:ss reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mw_cook_timer;

  localparam int TPS   = 4;
  localparam int BEEPS = 3;

  localparam int S_IDLE = 0, S_SET = 1, S_COOK = 2, S_PAUSE = 3, S_DONE = 4;

  logic       clk = 1'b0;
  logic       rstn, startn, stopn, clearn, door_closed, digit_valid;
  logic [3:0] digit;
  logic       mag, timer_done;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [2:0] dut_state;
  logic       beep;

  mw_cook_timer #(
    .TICKS_PER_SEC(TPS),
    .TICK_W       (16)
`ifdef MW_DONE_BEEP_EN
    ,
    .BEEP_SECS    (BEEPS)
`endif
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .startn     (startn),
    .stopn      (stopn),
    .clearn     (clearn),
    .door_closed(door_closed),
    .digit_valid(digit_valid),
    .digit      (digit),
    .mag        (mag),
    .timer_done (timer_done),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
`ifdef MW_DONE_BEEP_EN
    .beep       (beep),
`endif
    .state      (dut_state)
  );

`ifndef MW_DONE_BEEP_EN
  assign beep = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model: time kept as decimal mmss integer ----
  int m_state, m_time, m_presc, m_beep_left;
  bit m_mag, m_done, m_hs, m_hp, m_hc;

  function automatic void model_reset();
    m_state = S_IDLE; m_time = 0; m_presc = 0; m_beep_left = 0;
    m_mag = 0; m_done = 0; m_hs = 1; m_hp = 1; m_hc = 1;
  endfunction

  function automatic int dec_time(int t);
    int mins = t / 100;
    int secs = t % 100;
    if (secs > 0) secs = secs - 1;
    else begin mins = mins - 1; secs = 59; end
    return mins * 100 + secs;
  endfunction

  function automatic void model_step();
    bit sp = m_hs && !startn;
    bit pp = m_hp && !stopn;
    bit cp = m_hc && !clearn;
    int ns = m_state;
    m_done = 0;
    if (cp) begin
      ns = S_IDLE; m_time = 0;
    end else if (m_state == S_IDLE || m_state == S_SET) begin
      if (m_state == S_SET && sp && door_closed) begin
        ns = S_COOK; m_presc = 0;
      end else if (digit_valid && digit <= 9) begin
        m_time = (m_time % 1000) * 10 + int'(digit);
        ns = (m_time != 0) ? S_SET : S_IDLE;
      end
    end else if (m_state == S_COOK) begin
      if (pp || !door_closed) ns = S_PAUSE;
      else if (m_presc == TPS - 1) begin
        m_presc = 0;
        m_time  = dec_time(m_time);
        if (m_time == 0) begin ns = S_DONE; m_done = 1; end
      end else m_presc = m_presc + 1;
    end else if (m_state == S_PAUSE) begin
      if (pp) begin ns = S_IDLE; m_time = 0; end
      else if (sp && door_closed) begin ns = S_COOK; m_presc = 0; end
    end else if (m_state == S_DONE) begin
      if (pp || !door_closed) ns = S_IDLE;
    end
    if (ns == S_DONE) m_beep_left = (m_state != S_DONE) ? BEEPS * TPS
                                   : ((m_beep_left > 0) ? m_beep_left - 1 : 0);
    else m_beep_left = 0;
    m_state = ns;
    m_mag = (ns == S_COOK);
    m_hs = startn; m_hp = stopn; m_hc = clearn;
  endfunction

  function automatic logic [15:0] bcd16(int t);
    return {4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
  endfunction

  function automatic logic [31:0] dut_vec();
`ifdef MW_DONE_BEEP_EN
    return {10'd0, beep, dut_state, mag, timer_done, min_tens, min_ones, sec_tens, sec_ones};
`else
    return {11'd0, dut_state, mag, timer_done, min_tens, min_ones, sec_tens, sec_ones};
`endif
  endfunction

  function automatic logic [31:0] model_vec();
    logic [15:0] t = bcd16(m_time);
`ifdef MW_DONE_BEEP_EN
    logic b = (m_state == S_DONE) && (m_beep_left > 0);
    return {10'd0, b, 3'(m_state), m_mag, m_done, t};
`else
    return {11'd0, 3'(m_state), m_mag, m_done, t};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic key(input logic [3:0] d);
    digit_valid = 1'b1; digit = d; step(); digit_valid = 1'b0;
  endtask
  task automatic press_start(); startn = 1'b0; step(); startn = 1'b1; endtask
  task automatic press_stop();  stopn  = 1'b0; step(); stopn  = 1'b1; endtask
  task automatic press_clear(); clearn = 1'b0; step(); clearn = 1'b1; endtask

  function automatic logic [15:0] dut_time();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    bit dv; logic [3:0] dig; bit st_n; bit door;
    int e_state; logic [15:0] e_time; bit e_mag;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit dv, logic [3:0] dg, bit st_n, bit door,
                              int es, logic [15:0] et, bit em);
    vec_t v;
    v.dv = dv; v.dig = dg; v.st_n = st_n; v.door = door;
    v.e_state = es; v.e_time = et; v.e_mag = em;
    tbl.push_back(v);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int cnt;
    bit bad;
    rstn = 1'b0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door_closed = 1'b1; digit_valid = 1'b0; digit = 4'd0;
    model_reset();

    add(1, 4'hA, 1, 1, S_IDLE, 16'h0000, 0); // illegal digit in IDLE ignored
    add(1, 4'h0, 1, 1, S_IDLE, 16'h0000, 0); // zero keeps IDLE
    add(1, 4'h1, 1, 1, S_SET,  16'h0001, 0);
    add(1, 4'h0, 1, 1, S_SET,  16'h0010, 0);
    add(1, 4'hB, 1, 1, S_SET,  16'h0010, 0);
    add(0, 4'h0, 0, 0, S_SET,  16'h0010, 0); // start, door open: ignored
    add(0, 4'h0, 0, 1, S_SET,  16'h0010, 0); // still held: no new press
    add(0, 4'h0, 1, 1, S_SET,  16'h0010, 0);
    add(0, 4'h0, 0, 1, S_COOK, 16'h0010, 1);
    add(0, 4'h0, 0, 1, S_COOK, 16'h0010, 1);
    add(0, 4'h0, 0, 1, S_COOK, 16'h0010, 1);
    add(0, 4'h0, 0, 1, S_COOK, 16'h0010, 1);
    add(0, 4'h0, 1, 1, S_COOK, 16'h0009, 1); // 4 cycles after start

    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    check("reset_state", dut_vec(), 32'd0);

    foreach (tbl[i]) begin
      digit_valid = tbl[i].dv; digit = tbl[i].dig;
      startn = tbl[i].st_n; door_closed = tbl[i].door;
      step();
      check($sformatf("vec%0d", i),
            {dut_state, mag, dut_time()},
            {3'(tbl[i].e_state), tbl[i].e_mag, tbl[i].e_time});
    end
    digit_valid = 1'b0; startn = 1'b1; door_closed = 1'b1;

    // Remaining 9 seconds -> DONE at exactly 40 cycles after start
    bad = 0;
    for (int i = 0; i < 35; i++) begin step(); if (timer_done) bad = 1; end
    check("no_early_done", 32'(bad), 32'd0);
    step();
    check("done_edge", {dut_state, mag, timer_done, dut_time()}, {3'(S_DONE), 1'b0, 1'b1, 16'h0000});
    step();
    check("done_one_cycle", {dut_state, timer_done}, {3'(S_DONE), 1'b0});
    press_clear();

    // Borrow chains
    key(1); key(0); key(0); press_start();
    repeat (4) step();
    check("borrow_0100", dut_time(), 16'h0059);
    press_clear();
    key(1); key(0); key(0); key(0); press_start();
    repeat (4) step();
    check("borrow_1000", dut_time(), 16'h0959);
    press_clear();

    // Door open on a tick cycle
    key(6); press_start();
    repeat (4) step();
    check("pre_door_time", dut_time(), 16'h0005);
    repeat (3) step();
    door_closed = 1'b0; step();
    check("door_pause", {dut_state, mag, dut_time()}, {3'(S_PAUSE), 1'b0, 16'h0005});
    door_closed = 1'b1; repeat (3) step();
    check("closed_stay_pause", 32'(dut_state), S_PAUSE);
    press_start();
    check("resume", {dut_state, mag}, {3'(S_COOK), 1'b1});
    repeat (4) step();
    check("resume_tick", dut_time(), 16'h0004);
    press_clear();

    // Held start yields one press only
    key(3); key(0);
    startn = 1'b0; step();
    stopn = 1'b0; step(); stopn = 1'b1;
    bad = 0;
    for (int i = 0; i < 18; i++) begin step(); if (dut_state != 3'(S_PAUSE)) bad = 1; end
    check("held_start_once", 32'(bad), 32'd0);
    startn = 1'b1; step();
    press_stop();
    check("stop_in_pause", {dut_state, dut_time()}, {3'(S_IDLE), 16'h0000});

    // Clear beats start in the same cycle
    key(3);
    startn = 1'b0; clearn = 1'b0; step(); startn = 1'b1; clearn = 1'b1;
    check("clear_over_start", {dut_state, mag, dut_time()}, {3'(S_IDLE), 1'b0, 16'h0000});

    // Asynchronous reset mid-cook
    key(9); press_start(); repeat (2) step();
    #2 rstn = 1'b0;
    #1;
    check("async_reset", dut_vec(), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;

`ifdef MW_DONE_BEEP_EN
    key(1); press_start(); repeat (4) step();
    cnt = beep ? 1 : 0;
    for (int i = 0; i < 30; i++) begin step(); if (beep) cnt++; end
    check("beep_len", 32'(cnt), 32'(BEEPS * TPS));
    press_stop();
    key(1); press_start(); repeat (4) step();
    repeat (4) step();
    check("beep_mid", 32'(beep), 32'd1);
    press_stop();
    check("beep_cut", {dut_state, beep}, {3'(S_IDLE), 1'b0});
`else
    cnt = 0;
`endif

    // Random run against the model
    for (int i = 0; i < 2500; i++) begin
      digit_valid = ($urandom % 4) == 0;
      digit       = ($urandom % 3 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      startn      = ($urandom % 6) != 0;
      stopn       = ($urandom % 25) != 0;
      clearn      = ($urandom % 80) != 0;
      if ($urandom % 30 == 0) door_closed = ~door_closed;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
